// File: rtl/vco_adc_multich_counter.sv
// Multi-channel VCO ADC back-end: per-channel phase synchroniser and transition counter,
// windowed integrator, drain FSM and shared FWFT sample FIFO. Optional macro: VCO_ADC_SAT_EN.
module vco_adc_multich_counter #(
    parameter int NCH        = 2,
    parameter int PHASES     = 11,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = 3
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        enable,
    input  logic [15:0]                 win_len,
    input  logic [NCH*PHASES-1:0]       phase_in,
    output logic                        smp_valid,
    input  logic                        smp_ready,
    output logic [CNT_W-1:0]            smp_data,
    output logic [CH_W-1:0]             smp_chan,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overrun,
    input  logic                        ovr_clr,
    output logic [NCH-1:0]              sat
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int D_W   = $clog2(PHASES + 1);
    localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW    = CH_W + CNT_W;
    localparam logic [15:0] MIN_L = (NCH > 2) ? 16'(NCH) : 16'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic logic [D_W-1:0] popcount(input logic [PHASES-1:0] v);
        logic [D_W-1:0] n;
        n = '0;
        for (int i = 0; i < PHASES; i++) begin
            n = n + D_W'(v[i]);
        end
        return n;
    endfunction

    logic [NCH*PHASES-1:0] r_s1;
    logic [NCH*PHASES-1:0] r_s2;
    logic [NCH*PHASES-1:0] r_s3;
    logic [D_W-1:0]        w_d       [NCH];
    logic [CNT_W-1:0]      w_acc_nxt [NCH];
    logic [CNT_W-1:0]      r_acc     [NCH];
    logic [CNT_W-1:0]      r_snap    [NCH];
    logic [15:0]           r_wcnt;
    logic [15:0]           r_len;
    logic [15:0]           w_len_in;
    logic [15:0]           w_len_eff;
    logic                  w_end;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [KW-1:0]         r_k;
    logic [KW-1:0]         w_k_nxt;
    logic                  w_push;
    logic [DW-1:0]         w_push_word;
    logic [DW-1:0]         r_mem     [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_count;
    logic                  r_overrun;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;

    // Two-flop synchroniser per tap plus one history stage for edge detection
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= phase_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Per-channel count of phase transitions this cycle
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_d[c] = popcount(r_s2[c*PHASES +: PHASES] ^ r_s3[c*PHASES +: PHASES]);
        end
    end

`ifdef VCO_ADC_SAT_EN
    localparam int SUM_W = CNT_W + D_W;

    logic [SUM_W-1:0] w_sum [NCH];
    logic [NCH-1:0]   w_ovf;
    logic [NCH-1:0]   r_sat;

    // Saturating accumulate: clamp at all-ones and flag the channel
    always_comb begin
        w_ovf = '0;
        for (int c = 0; c < NCH; c++) begin
            w_sum[c] = SUM_W'(r_acc[c]) + SUM_W'(w_d[c]);
            if (w_sum[c][SUM_W-1:CNT_W] != '0) begin
                w_ovf[c]     = 1'b1;
                w_acc_nxt[c] = {CNT_W{1'b1}};
            end else begin
                w_ovf[c]     = 1'b0;
                w_acc_nxt[c] = w_sum[c][CNT_W-1:0];
            end
        end
    end

    // Sticky saturation flags, cleared only by reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sat <= '0;
        end else if (enable) begin
            r_sat <= r_sat | w_ovf;
        end else begin
            r_sat <= r_sat;
        end
    end

    assign sat = r_sat;
`else
    // Wrapping accumulate modulo 2^CNT_W
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_acc_nxt[c] = r_acc[c] + CNT_W'(w_d[c]);
        end
    end

    assign sat = '0;
`endif

    // Window length: clamped input at window start, latched value afterwards
    always_comb begin
        if (win_len < MIN_L) begin
            w_len_in = MIN_L;
        end else begin
            w_len_in = win_len;
        end
        if (r_wcnt == 16'd0) begin
            w_len_eff = w_len_in;
        end else begin
            w_len_eff = r_len;
        end
        w_end = enable && (r_wcnt == (w_len_eff - 16'd1));
    end

    // Window counter, accumulators and end-of-window snapshot
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wcnt <= 16'd0;
            r_len  <= 16'd0;
            for (int c = 0; c < NCH; c++) begin
                r_acc[c]  <= '0;
                r_snap[c] <= '0;
            end
        end else if (!enable) begin
            r_wcnt <= 16'd0;
            for (int c = 0; c < NCH; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            if (r_wcnt == 16'd0) begin
                r_len <= w_len_in;
            end
            r_wcnt <= w_end ? 16'd0 : (r_wcnt + 16'd1);
            for (int c = 0; c < NCH; c++) begin
                if (w_end) begin
                    r_snap[c] <= w_acc_nxt[c];
                    r_acc[c]  <= '0;
                end else begin
                    r_acc[c]  <= w_acc_nxt[c];
                end
            end
        end
    end

    // Drain FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Drain sequencing; with L == NCH a new window can end on the last push, so restart in place
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_push      = 1'b0;
        w_push_word = {CH_W'(r_k), r_snap[r_k]};
        case (r_state)
            ST_IDLE: begin
                if (w_end) begin
                    w_state_nxt = ST_DRAIN;
                    w_k_nxt     = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_push = 1'b1;
                if (r_k == KW'(NCH - 1)) begin
                    w_k_nxt     = '0;
                    w_state_nxt = w_end ? ST_DRAIN : ST_IDLE;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    // FIFO handshake decode; a pop frees the slot for a same-cycle push when full
    always_comb begin
        w_pop  = (r_count != LW'(0)) && smp_ready;
        w_full = (r_count == LW'(FIFO_DEPTH));
        w_wr   = w_push && (!w_full || w_pop);
        w_drop = w_push && w_full && !w_pop;
    end

    // FIFO storage, pointers, occupancy and sticky overrun
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign smp_valid             = (r_count != LW'(0));
    assign {smp_chan, smp_data}  = r_mem[r_rd_ptr];
    assign fifo_level            = r_count;
    assign overrun               = r_overrun;

endmodule

// File: tb/tb_vco_adc_multich_counter.sv
// Directed bench for vco_adc_multich_counter (NCH=2, CNT_W=4 so saturation/wrap is reachable).
module tb_vco_adc_multich_counter;

    localparam int NCH        = 2;
    localparam int PHASES     = 11;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CH_W       = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [15:0]           win_len;
    logic [NCH*PHASES-1:0] phase_in;
    logic                  smp_valid;
    logic                  smp_ready;
    logic [CNT_W-1:0]      smp_data;
    logic [CH_W-1:0]       smp_chan;
    logic [3:0]            fifo_level;
    logic                  overrun;
    logic                  ovr_clr;
    logic [NCH-1:0]        sat;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] got_q[$];

    always #5 clk = ~clk;

    vco_adc_multich_counter #(
        .NCH(NCH), .PHASES(PHASES), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .CH_W(CH_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .win_len(win_len),
        .phase_in(phase_in), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_data(smp_data), .smp_chan(smp_chan), .fifo_level(fifo_level),
        .overrun(overrun), .ovr_clr(ovr_clr), .sat(sat)
    );

    // Record every accepted sample as {chan, data}
    always @(posedge clk) begin
        if (!rst && smp_valid && smp_ready) got_q.push_back({smp_chan, smp_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [NCH*PHASES-1:0] mask);
        for (int i = 0; i < n; i++) begin
            phase_in = phase_in ^ mask;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; smp_ready = 1'b1; ovr_clr = 1'b0;
        phase_in = '0; win_len = 16'd4;
        tick(); tick();
        rst = 1'b0;
        got_q.delete();
    endtask

    function automatic logic [31:0] qget(input int i);
        if (i < got_q.size()) return 32'(got_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ent(input int ch, input int val);
        return (ch << CNT_W) | val;
    endfunction

    initial begin
        int p;
        int exp6;
        int exp_ch0[6];

        // Test 1: reset values and first-sample latency with static phases
        do_reset();
        check("rst valid", 32'(smp_valid), 32'd0);
        check("rst data", 32'(smp_data), 32'd0);
        check("rst chan", 32'(smp_chan), 32'd0);
        check("rst level", 32'(fifo_level), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst sat", 32'(sat), 32'd0);
        win_len = 16'd4;
        enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            p = (i >= 5) ? ((i - 5) % 4) : 3;
            check($sformatf("t1 valid c%0d", i), 32'(smp_valid), (p < 2) ? 32'd1 : 32'd0);
            if (p < 2) begin
                check($sformatf("t1 chan c%0d", i), 32'(smp_chan), 32'(p));
                check($sformatf("t1 data c%0d", i), 32'(smp_data), 32'd0);
            end
            run(1, '0);
        end

        // Test 2: ch0 one toggling tap, win_len=10 -> ch0=10, ch1=0, alternating tags
        do_reset();
        win_len = 16'd10;
        run(5, 22'h1);
        enable = 1'b1;
        run(46, 22'h1);
        enable = 1'b0;
        run(4, '0);
        check("t2 count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2 q%0d", i), qget(i), (i % 2 == 0) ? ent(0, 10) : ent(1, 0));

        // Test 3: fill FIFO with smp_ready=0, overrun, clear, then full+pop
        do_reset();
        smp_ready = 1'b0;
        win_len = 16'd2;
        phase_in = 22'h1;
        run(2, '0);
        enable = 1'b1;
        run(10, '0);
        check("t3 level full", 32'(fifo_level), 32'd8);
        check("t3 no ovr yet", 32'(overrun), 32'd0);
        run(1, '0);
        check("t3 overrun", 32'(overrun), 32'd1);
        check("t3 level hold", 32'(fifo_level), 32'd8);
        check("t3 head valid", 32'(smp_valid), 32'd1);
        check("t3 head chan", 32'(smp_chan), 32'd0);
        check("t3 head data", 32'(smp_data), 32'd1);
        enable = 1'b0;
        run(1, '0);
        ovr_clr = 1'b1;
        run(1, '0);
        ovr_clr = 1'b0;
        check("t3 ovr cleared", 32'(overrun), 32'd0);
        check("t3 level kept", 32'(fifo_level), 32'd8);
        got_q.delete();
        enable = 1'b1;
        run(1, '0);
        run(1, '0);
        smp_ready = 1'b1;
        enable = 1'b0;
        run(1, '0);
        smp_ready = 1'b0;
        check("t3 full+pop level", 32'(fifo_level), 32'd8);
        check("t3 full+pop ovr", 32'(overrun), 32'd0);
        run(1, '0);
        check("t3 reovr", 32'(overrun), 32'd1);
        smp_ready = 1'b1;
        run(12, '0);
        check("t3 drained level", 32'(fifo_level), 32'd0);
        check("t3 drained valid", 32'(smp_valid), 32'd0);
        check("t3 count", 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            check($sformatf("t3 q%0d", i), qget(i),
                  (i == 0) ? ent(0, 1) : ((i % 2 == 1) ? ent(1, 0) : ent(0, 0)));

        // Test 4: win_len=1 clamps to 2; mid-window changes apply at next window start
        do_reset();
        win_len = 16'd1;
        run(5, 22'h1);
        enable = 1'b1;
        run(5, 22'h1);
        win_len = 16'd8;
        run(11, 22'h1);
        win_len = 16'd13;
        run(24, 22'h1);
        enable = 1'b0;
        run(4, 22'h1);
        run(3, '0);
        exp_ch0 = '{2, 2, 2, 8, 8, 13};
        check("t4 count", 32'(got_q.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("t4 q%0d", i), qget(i),
                  (i % 2 == 0) ? ent(0, exp_ch0[i/2]) : ent(1, 0));

        // Test 5: enable dropped mid-window discards it; re-enable gives a full window
        do_reset();
        win_len = 16'd10;
        run(5, 22'h1);
        enable = 1'b1;
        run(15, 22'h1);
        enable = 1'b0;
        run(3, 22'h1);
        enable = 1'b1;
        run(14, 22'h1);
        enable = 1'b0;
        run(3, '0);
        check("t5 count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t5 q%0d", i), qget(i), (i % 2 == 0) ? ent(0, 10) : ent(1, 0));

        // Test 6: all 11 taps of ch0 toggling, win_len=8 -> 88 counts per window
        do_reset();
        win_len = 16'd8;
        run(5, 22'h7FF);
        enable = 1'b1;
        run(12, 22'h7FF);
`ifdef VCO_ADC_SAT_EN
        exp6 = 15;
        check("t6 sat", 32'(sat), 32'd1);
`else
        exp6 = 8;
        check("t6 sat", 32'(sat), 32'd0);
`endif
        check("t6 ch0", qget(0), ent(0, exp6));
        check("t6 ch1", qget(1), ent(1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
